opb_register_simulink2ppc: RTL and testbench
============================================

Name: opb_register_simulink2ppc

Overview:
- OPB slave register that lets the PowerPC read values produced by the fabric (Simulink) design, i.e. the fabric-to-processor direction.
- Fabric logic strobes a 32-bit word in; the PPC reads it, a status word and a capture counter over OPB.
- Sits on the same OPB bus as the ppc2simulink registers, with its own address window.
- Single clock domain: the fabric side runs on OPB_Clk.

Parameters:
- C_BASEADDR, 32'h01000700, first byte address of the window.
- C_HIGHADDR, 32'h010007FF, last byte address of the window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_FAMILY, "virtex5", target family; informational only.

Ports:
- OPB_Clk  in  1  sole clock for OPB and fabric sides.
- OPB_Rst  in  1  reset, synchronous, active-high.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; ignored, full-word access only.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer valid.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- user_data_in  in  [31:0]  word from the fabric.
- user_data_valid  in  1  capture strobe, one word per high cycle.

Behaviour:
- Clock and reset: one clock, OPB_Clk; reset OPB_Rst is synchronous and active-high.
- Reset values: Sl_DBus=0, Sl_xferAck=0, data_reg=0, new_flag=0, ovf_flag=0, cap_count=0, FSM=IDLE.
- Bit mapping: user_data_in[31-i] maps to Sl_DBus[i]; the LSB of every register is Sl_DBus[31].

Address decode:
- hit = OPB_select and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Word offset is OPB_ABus[28:29].
- Offset 0x0 DATA: data_reg.
- Offset 0x4 STATUS: bit0 = new_flag, bit1 = ovf_flag, other bits 0.
- Offset 0x8 COUNT: bits[15:0] = cap_count, other bits 0.
- Offset 0xC: reads 0.
- Other addresses inside the window alias by offset.

FSM (registered):
- IDLE -> ACK when hit.
- ACK: Sl_xferAck=1 for exactly one cycle; on a read, Sl_DBus carries the selected register. Always -> HOLD.
- HOLD -> IDLE when OPB_select=0. Stays in HOLD while select remains high, so no second ack for the same transfer.
- Latency: hit sampled at edge N; ack and data are valid in cycle N+1.
- Sl_DBus is 0 in every cycle except a read ACK, because the OPB data bus is OR-combined.

Writes:
- Always acked with the same timing as reads.
- A write to COUNT zeroes cap_count on the ACK cycle.
- Writes to any other offset are ignored.

Capture:
- On user_data_valid: data_reg <= user_data_in, new_flag <= 1, cap_count <= cap_count + 1 (16-bit, wraps 0xFFFF -> 0).
- ovf_flag <= 1 if new_flag was already 1.

Read-clear:
- A read ACK at DATA clears new_flag and ovf_flag.

Simultaneous events:
- Capture in the same cycle as a DATA read ACK: the read returns the old data_reg; capture wins, so new_flag=1 and ovf_flag is unchanged.
- Capture in the same cycle as a COUNT write ACK: clear wins, cap_count=0.

Other boundaries:
- Reset asserted mid-transfer: FSM goes to IDLE and no ack is issued. A select still held after reset re-enters ACK.
- A miss (address outside the window) never acks; the bus times out in the arbiter.

Test Plan:
- Reset, then read 0x01000700, 0x01000704, 0x01000708 -> each returns 0x00000000, with Sl_xferAck high exactly one cycle after select.
- Strobe 0xDEADBEEF once, then read STATUS -> 0x00000001. Read DATA -> 0xDEADBEEF. Read STATUS again -> 0x00000000.
- Strobe 0x1 then 0x2 with no read -> STATUS reads 0x00000003 and DATA reads 0x00000002; the DATA read clears STATUS to 0.
- Strobe 0x55 in the same cycle as a DATA read ACK for a prior 0x44 -> read returns 0x00000044; STATUS then reads 0x00000001 and DATA reads 0x00000055.
- 65537 strobes -> COUNT reads 0x00000001. Write any value to 0x01000708 -> COUNT reads 0. Hold select high 5 cycles -> only one xferAck.
- Assert OPB_Rst in the ACK-pending cycle -> no Sl_xferAck, all registers 0. Read of 0x01000800 -> no ack and Sl_DBus stays 0.

Source files
------------

// File: rtl/opb_register_simulink2ppc.sv
// OPB slave exposing a fabric-captured word, its new/overflow status and a
// 16-bit capture counter to the PowerPC (fabric-to-processor direction).
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01000700,
  parameter logic [31:0] C_HIGHADDR   = 32'h010007FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [31:0]               user_data_in,
  input  logic                      user_data_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam bit FAMILY_SET_LP = (C_FAMILY != "");

  state_e      state_q;
  logic        ack_q;
  logic [31:0] dbus_q;
  logic        rnw_q;
  logic [1:0]  off_q;

  logic [31:0] data_q, data_d;
  logic        new_q, new_d;
  logic        ovf_q, ovf_d;
  logic [15:0] count_q, count_d;

  logic        hit_s;
  logic [1:0]  off_s;
  logic [31:0] rd_word_s;
  logic        rd_clr_s;
  logic        cnt_clr_s;
  logic        unused_ok_s;

  assign unused_ok_s = ^{OPB_BE, OPB_DBus, OPB_seqAddr, FAMILY_SET_LP};

  assign off_s     = OPB_ABus[28:29];
  assign hit_s     = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  // Side effects belong to the ACK cycle, using the offset latched at the hit.
  assign rd_clr_s  = (state_q == ST_ACK) && rnw_q && (off_q == 2'd0);
  assign cnt_clr_s = (state_q == ST_ACK) && !rnw_q && (off_q == 2'd2);

  always_comb begin
    case (off_s)
      2'd0:    rd_word_s = data_q;
      2'd1:    rd_word_s = {30'd0, ovf_q, new_q};
      2'd2:    rd_word_s = {16'd0, count_q};
      default: rd_word_s = 32'd0;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dbus_q  <= 32'd0;
      rnw_q   <= 1'b0;
      off_q   <= 2'd0;
    end else begin
      ack_q  <= 1'b0;
      dbus_q <= 32'd0;
      case (state_q)
        ST_IDLE: begin
          if (hit_s) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            rnw_q   <= OPB_RNW;
            off_q   <= off_s;
            dbus_q  <= OPB_RNW ? rd_word_s : 32'd0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACK:  state_q <= ST_HOLD;
        ST_HOLD: state_q <= OPB_select ? ST_HOLD : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Capture beats read-clear on new_flag; a counter clear beats a capture.
  always_comb begin
    data_d  = data_q;
    new_d   = new_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (user_data_valid) begin
      data_d  = user_data_in;
      new_d   = 1'b1;
      ovf_d   = rd_clr_s ? ovf_q : (ovf_q | new_q);
      count_d = count_q + 16'd1;
    end else if (rd_clr_s) begin
      new_d = 1'b0;
      ovf_d = 1'b0;
    end else begin
      new_d = new_q;
    end
    if (cnt_clr_s) begin
      count_d = 16'd0;
    end else begin
      count_d = count_d;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      data_q  <= 32'd0;
      new_q   <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= 16'd0;
    end else begin
      data_q  <= data_d;
      new_q   <= new_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Scoreboard bench: the driver pushes expected acks from a register-level
// model; a negedge monitor pops them and checks data and ack cycle.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01000700;
  localparam logic [31:0] HIGH = 32'h010007FF;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst = 1'b1;
  logic [0:31] OPB_ABus = 32'd0;
  logic [0:3]  OPB_BE = 4'd0;
  logic [0:31] OPB_DBus = 32'd0;
  logic        OPB_RNW = 1'b0;
  logic        OPB_select = 1'b0;
  logic        OPB_seqAddr = 1'b0;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [31:0] user_data_in = 32'd0;
  logic        user_data_valid = 1'b0;

  opb_register_simulink2ppc dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .user_data_in(user_data_in), .user_data_valid(user_data_valid)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge OPB_Clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: register contents as plain values
  logic [31:0] m_data = 32'd0;
  bit          m_new = 1'b0;
  bit          m_ovf = 1'b0;
  int          m_count = 0;

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0:       return m_data;
      1:       return (m_ovf ? 32'd2 : 32'd0) + (m_new ? 32'd1 : 32'd0);
      2:       return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_capture(input logic [31:0] v);
    m_ovf   = m_ovf | m_new;
    m_new   = 1'b1;
    m_data  = v;
    m_count = (m_count + 1) % 65536;
  endfunction

  // Monitor: every ack must match the head of the scoreboard; otherwise the bus is quiet
  always @(negedge OPB_Clk) begin
    if (mon_en) begin
      if (Sl_xferAck === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack cycle=%0d dbus=%h required=no ack", cyc, Sl_DBus);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cyc != e.cyc) begin
            failures++;
            $display("FAIL ack_cycle actual=%0d required=%0d", cyc, e.cyc);
          end
          checks++;
          if (Sl_DBus !== e.data) begin
            failures++;
            $display("FAIL read_data actual=%h required=%h", Sl_DBus, e.data);
          end
        end
      end else begin
        checks++;
        if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'd0 || Sl_errAck !== 1'b0 ||
            Sl_retry !== 1'b0 || Sl_toutSup !== 1'b0) begin
          failures++;
          $display("FAIL idle_bus cycle=%0d ack=%b dbus=%h err=%b retry=%b tout=%b required=0",
                   cyc, Sl_xferAck, Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge OPB_Clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_acks=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic capture(input logic [31:0] v);
    @(posedge OPB_Clk); #1;
    user_data_valid = 1'b1;
    user_data_in    = v;
    @(posedge OPB_Clk); #1;
    user_data_valid = 1'b0;
    user_data_in    = $urandom;
    model_capture(v);
  endtask

  task automatic bus(input logic [31:0] addr, input logic rnw, input int hold);
    bit   hit;
    int   off;
    exp_t e;
    hit = (addr >= BASE) && (addr <= HIGH);
    off = int'((addr >> 2) & 32'd3);
    @(posedge OPB_Clk); #1;
    OPB_ABus   = addr;
    OPB_RNW    = rnw;
    OPB_DBus   = $urandom;
    OPB_BE     = 4'hF;
    OPB_select = 1'b1;
    if (hit) begin
      e.data = rnw ? model_read(off) : 32'd0;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    repeat (hold) @(posedge OPB_Clk);
    #1;
    OPB_select = 1'b0;
    OPB_ABus   = 32'd0;
    if (hit && rnw && off == 0) begin
      m_new = 1'b0;
      m_ovf = 1'b0;
    end
    if (hit && !rnw && off == 2) m_count = 0;
    idle(2);
    check_drained("xfer");
  endtask

  initial begin
    #2_000_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge OPB_Clk);
    #1;
    mon_en = 1'b1;
    idle(2);
    OPB_Rst = 1'b0;

    // Reset values
    bus(BASE + 32'h0, 1'b1, 2);
    bus(BASE + 32'h4, 1'b1, 2);
    bus(BASE + 32'h8, 1'b1, 2);

    // Single capture, status, read-clear
    capture(32'hDEADBEEF);
    bus(BASE + 32'h4, 1'b1, 2);
    bus(BASE + 32'h0, 1'b1, 2);
    bus(BASE + 32'h4, 1'b1, 2);

    // Overflow
    capture(32'h1);
    capture(32'h2);
    bus(BASE + 32'h4, 1'b1, 2);
    bus(BASE + 32'h0, 1'b1, 2);
    bus(BASE + 32'h4, 1'b1, 2);

    // Capture during the ACK cycle of a DATA read
    capture(32'h44);
    @(posedge OPB_Clk); #1;
    OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_select = 1'b1;
    e.data = model_read(0); e.cyc = cyc + 1;
    exp_q.push_back(e);
    @(posedge OPB_Clk); #1;
    user_data_valid = 1'b1; user_data_in = 32'h55;
    @(posedge OPB_Clk); #1;
    user_data_valid = 1'b0; OPB_select = 1'b0;
    m_data = 32'h55; m_new = 1'b1; m_count = (m_count + 1) % 65536;
    idle(2);
    check_drained("cap_during_ack");
    bus(BASE + 32'h4, 1'b1, 2);
    bus(BASE + 32'h0, 1'b1, 2);

    // Counter wrap, count clear, long select
    bus(BASE + 32'h8, 1'b0, 2);
    @(posedge OPB_Clk); #1;
    for (int i = 0; i < 65537; i++) begin
      user_data_valid = 1'b1;
      user_data_in    = $urandom;
      model_capture(user_data_in);
      @(posedge OPB_Clk); #1;
    end
    user_data_valid = 1'b0;
    bus(BASE + 32'h8, 1'b1, 2);
    bus(BASE + 32'h8, 1'b0, 2);
    bus(BASE + 32'h8, 1'b1, 2);
    bus(BASE + 32'h0, 1'b1, 5);
    bus(BASE + 32'hC, 1'b1, 2);

    // Reset in the ACK-pending cycle, select kept high afterwards
    capture(32'hA5A5_0F0F);
    @(posedge OPB_Clk); #1;
    OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_select = 1'b1; OPB_Rst = 1'b1;
    @(posedge OPB_Clk); #1;
    OPB_Rst = 1'b0;
    m_data = 32'd0; m_new = 1'b0; m_ovf = 1'b0; m_count = 0;
    e.data = 32'd0; e.cyc = cyc + 1;
    exp_q.push_back(e);
    idle(2);
    OPB_select = 1'b0;
    idle(2);
    check_drained("reset_mid_xfer");
    bus(BASE + 32'h0, 1'b1, 2);
    bus(BASE + 32'h4, 1'b1, 2);
    bus(BASE + 32'h8, 1'b1, 2);

    // Misses on either side of the window
    bus(32'h01000800, 1'b1, 3);
    bus(32'h010006FC, 1'b1, 3);

    // Randomized traffic with aliasing inside the window
    for (int n = 0; n < 300; n++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 5));
      a  = BASE + ($urandom_range(0, 255) & 32'hFFFF_FFFC);
      case (op)
        0, 1:    capture($urandom);
        2, 3:    bus(a, 1'b1, int'($urandom_range(2, 4)));
        4:       bus(a, 1'b0, int'($urandom_range(2, 4)));
        default: bus(32'h01000800 + ($urandom_range(0, 63) << 2), 1'b1, 2);
      endcase
    end
    bus(BASE + 32'h4, 1'b1, 2);
    bus(BASE + 32'h8, 1'b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
